mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree built from 2:1 mux stages, one register rank per tree level. It selects one of CHANNELS input words of WIDTH bits, carrying the select and a valid flag alongside the data so that each output word is tagged with the channel it came from. It is the next generation of the team's combinational 8:1 tree and is used wherever a wide channel mux must close timing at speed. An optional auto-scan mode walks the channels round-robin without external select traffic.

## Interface
- WIDTH, 8, bits per channel word (>=1)
- CHANNELS, 8, number of input channels (>=2; need not be a power of two)
- SELW, $clog2(CHANNELS), select width; also pipeline depth L
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  pipeline advance enable; 0 freezes every register
- in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_sel  in  SELW  channel select, sampled with in_valid
- in_valid  in  1  input word valid
- scan  in  1  1 = internal scan counter drives select (only with SCAN macro)
- out_data  out  WIDTH  selected word
- out_sel  out  SELW  channel index that produced out_data
- out_valid  out  1  out_data/out_sel valid

## Operation
- Tree padded to 2^SELW leaves; leaves c >= CHANNELS read as all-zero.
- Level k (k = 0..SELW-1) is a row of 2:1 muxes steered by select bit k (LSB at the leaves), followed by a register rank; the level holds 2^(SELW-1-k) words.
- The full select word and valid bit travel with the data through every rank.
- in_sel >= CHANNELS (non-power-of-two CHANNELS): out_data = 0, out_valid follows in_valid, out_sel = in_sel unchanged.
- in_valid = 0: bubble propagates; out_valid = 0 for that slot. Data registers still load, so out_data is don't-care when out_valid = 0.
- en = 0: all data, select, valid and scan registers hold; no word is lost or duplicated.
- Effective select = scan counter when the macro is defined and scan = 1; otherwise in_sel.

## Timing
- Latency L = SELW cycles: a word presented at edge t with en = 1 on every edge t..t+L-1 appears on the outputs after edge t+L-1.
- Throughput: one word per enabled cycle.
- Reset, synchronous on clk: out_data = 0, out_sel = 0, out_valid = 0, all internal ranks and valids = 0, scan counter = 0. rst overrides en.
- Reset mid-operation: all in-flight words are discarded; the first post-reset output valid appears L enabled cycles after the first valid input.
- Stage k valid register loads in_valid delayed k cycles; no combinational path from any input to any output.

## Configuration
- MUX_TREE_SCAN_EN defined: a SELW-bit scan counter is built. When scan = 1, the counter supplies the select; it advances by 1 on each edge with en = 1, in_valid = 1 and rst = 0, and wraps from CHANNELS-1 to 0 (never emits indices >= CHANNELS). It holds its value while scan = 0 and restarts from its held value when scan returns to 1.
- MUX_TREE_SCAN_EN undefined: no counter; the scan port exists but is ignored; select is always in_sel.

## Test plan
- WIDTH=8, CHANNELS=8, in_data channel c = 8'h10+c, in_sel 0..7 on consecutive cycles with in_valid=1, en=1 -> after 3 cycles outputs 8'h10..8'h17 on consecutive cycles with out_sel 0..7 and out_valid=1.
- Same setup, en=0 for 2 cycles mid-stream -> outputs freeze for exactly 2 cycles, then the sequence continues with no gap, repeat or loss.
- CHANNELS=5 (SELW=3), in_sel=6, in_valid=1 -> after 3 cycles out_data=0, out_sel=6, out_valid=1; in_sel=4 -> channel 4 data.
- Alternating in_valid 1/0 with in_sel=3 -> out_valid toggles 1/0 with latency 3; out_data=8'h13 on valid slots.
- rst=1 for one cycle while 3 words are in flight -> next cycle all outputs 0 and out_valid=0; no stale word is emitted afterwards.
- With MUX_TREE_SCAN_EN, CHANNELS=5, scan=1, in_valid=1 for 12 cycles -> out_sel sequence 0,1,2,3,4,0,1,2,3,4,0,1 starting at cycle 3 after reset; without the macro, out_sel tracks in_sel.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree built from 2:1 stages with one register rank per level; select and valid
// travel with the data. Optional round-robin auto-scan select is built when MUX_TREE_SCAN_EN is defined.
module mux_tree_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]           in_sel,
  input  logic                      in_valid,
  input  logic                      scan,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid
);

  localparam int LEAVES = 1 << SELW;
  localparam int HALF   = LEAVES / 2;

  logic [WIDTH-1:0] w_leaf [LEAVES];
  logic [SELW-1:0]  w_sel;

  // Leaves beyond the last real channel read as zero, so out-of-range selects yield zero data.
  for (genvar c = 0; c < LEAVES; c++) begin : g_leaf
    if (c < CHANNELS) begin : g_real
      assign w_leaf[c] = in_data[c*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_leaf[c] = {WIDTH{1'b0}};
    end
  end

`ifdef MUX_TREE_SCAN_EN
  logic [SELW-1:0] r_scan_cnt;

  // Round-robin channel counter; advances only when it actually supplies an accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
    end else if (en && scan && in_valid) begin
      if (r_scan_cnt == SELW'(CHANNELS - 1)) begin
        r_scan_cnt <= '0;
      end else begin
        r_scan_cnt <= r_scan_cnt + SELW'(1);
      end
    end
  end

  assign w_sel = scan ? r_scan_cnt : in_sel;
`else
  logic w_unused_scan;
  assign w_unused_scan = scan;
  assign w_sel         = in_sel;
`endif

  for (genvar k = 0; k < SELW; k++) begin : g_lvl
    localparam int N = HALF >> k;
    logic [WIDTH-1:0] r_word [N];
    logic [SELW-1:0]  r_sel;
    logic             r_valid;

    if (k == 0) begin : g_first
      // Leaf level: pairs of channels steered by select bit 0.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < N; j++) begin
            r_word[j] <= {WIDTH{1'b0}};
          end
          r_sel   <= '0;
          r_valid <= 1'b0;
        end else if (en) begin
          for (int j = 0; j < N; j++) begin
            r_word[j] <= w_sel[0] ? w_leaf[2*j+1] : w_leaf[2*j];
          end
          r_sel   <= w_sel;
          r_valid <= in_valid;
        end
      end
    end else begin : g_next
      // Inner level: reduce the previous rank using the select bit carried alongside it.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < N; j++) begin
            r_word[j] <= {WIDTH{1'b0}};
          end
          r_sel   <= '0;
          r_valid <= 1'b0;
        end else if (en) begin
          for (int j = 0; j < N; j++) begin
            r_word[j] <= g_lvl[k-1].r_sel[k] ? g_lvl[k-1].r_word[2*j+1] : g_lvl[k-1].r_word[2*j];
          end
          r_sel   <= g_lvl[k-1].r_sel;
          r_valid <= g_lvl[k-1].r_valid;
        end
      end
    end
  end

  assign out_data  = g_lvl[SELW-1].r_word[0];
  assign out_sel   = g_lvl[SELW-1].r_sel;
  assign out_valid = g_lvl[SELW-1].r_valid;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: an 8-channel and a 5-channel instance share one stimulus stream.
module tb_mux_tree_pipe;

  localparam int L = 3;

  typedef struct {
    logic       v;
    logic [7:0] data;
    logic [2:0] sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, scan;
  logic [2:0]  in_sel;
  logic [63:0] in_data8;
  logic [39:0] in_data5;
  logic [7:0]  od [2];
  logic [2:0]  os [2];
  logic        ov [2];
  logic [7:0]  pd [2];
  logic [2:0]  ps [2];
  logic        pv [2];
  logic [2:0]  m_cnt [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mux_tree_pipe #(.WIDTH(8), .CHANNELS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data8), .in_sel(in_sel),
    .in_valid(in_valid), .scan(scan), .out_data(od[0]), .out_sel(os[0]), .out_valid(ov[0])
  );

  mux_tree_pipe #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data5), .in_sel(in_sel),
    .in_valid(in_valid), .scan(scan), .out_data(od[1]), .out_sel(os[1]), .out_valid(ov[1])
  );

  function automatic int chans(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  function automatic logic [7:0] exp_word(input int d, input logic [2:0] s);
    if (int'(s) < chans(d)) return 8'h10 + {5'b00000, s};
    return 8'h00;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, (d == 0) ? 8 : 5, act, req, $time);
    end
  endtask

  // Scoreboard feeder: every enabled edge enqueues the expected response for that slot.
  always @(posedge clk) begin
    exp_t item;
    logic [2:0] s;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_cnt[0] <= 3'd0;
      m_cnt[1] <= 3'd0;
    end else if (en) begin
      for (int d = 0; d < 2; d++) begin
        s = in_sel;
`ifdef MUX_TREE_SCAN_EN
        if (scan) s = m_cnt[d];
        if (scan && in_valid) m_cnt[d] <= (int'(m_cnt[d]) == chans(d) - 1) ? 3'd0 : m_cnt[d] + 3'd1;
`endif
        item.v = in_valid;
        item.sel = s;
        item.data = exp_word(d, s);
        if (d == 0) q0.push_back(item);
        else q1.push_back(item);
      end
    end
  end

  // Monitor: compares DUT outputs shortly after each edge against reset, hold or scoreboard values.
  always @(posedge clk) begin
    logic e, r;
    int sz;
    exp_t it;
    e = en;
    r = rst;
    #1;
    for (int d = 0; d < 2; d++) begin
      sz = (d == 0) ? q0.size() : q1.size();
      if (r) begin
        chk("reset_data", d, int'(od[d]), 0);
        chk("reset_sel", d, int'(os[d]), 0);
        chk("reset_valid", d, int'(ov[d]), 0);
      end else if (!e) begin
        chk("hold_data", d, int'(od[d]), int'(pd[d]));
        chk("hold_sel", d, int'(os[d]), int'(ps[d]));
        chk("hold_valid", d, int'(ov[d]), int'(pv[d]));
      end else if (sz >= L) begin
        it = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("valid", d, int'(ov[d]), int'(it.v));
        if (it.v) begin
          chk("data", d, int'(od[d]), int'(it.data));
          chk("sel", d, int'(os[d]), int'(it.sel));
        end
      end else begin
        chk("fill_valid", d, int'(ov[d]), 0);
      end
      pd[d] = od[d];
      ps[d] = os[d];
      pv[d] = ov[d];
    end
  end

  task automatic drive(input logic r, input logic e, input logic v, input logic [2:0] s, input logic sc);
    @(negedge clk);
    rst = r;
    en = e;
    in_valid = v;
    in_sel = s;
    scan = sc;
  endtask

  initial begin
    for (int c = 0; c < 8; c++) in_data8[c*8 +: 8] = 8'h10 + 8'(c);
    for (int c = 0; c < 5; c++) in_data5[c*8 +: 8] = 8'h10 + 8'(c);
    rst = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    in_sel = 3'd0;
    scan = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 3'd5, 1'b0);
    // full sweep, including out-of-range selects on the 5-channel instance
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 3'(i), 1'b0);
    // second sweep with a two-cycle stall in the middle
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        drive(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b1, 3'(i), 1'b0);
    end
    // alternating bubbles on channel 3
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, (i % 2) == 0, 3'd3, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'd6, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    // three words in flight, then a one-cycle reset with en low
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 3'(i + 1), 1'b0);
    drive(1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 3'(7 - i), 1'b0);
    // scan mode with a changing external select
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 1'b1, 3'(7 - (i % 8)), 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
